wb_exception_stage: RTL and testbench

- Registered writeback-select stage between the execute/memory pipeline and the register file.
- Substitutes the status-register write (exception code) for any ALU result that raised an exception.
- Substitutes the link-register write (PC+1) for jal.
- Keeps a sticky first-exception record and a saturating exception counter for the bex/debug path.
- Generalises the combinational overflow/jal writeback mux: parametrised widths, more exception causes, a mask, stall and a sticky status.

---
 rtl/wb_exception_stage_pkg.sv | 21 ++
 rtl/wb_exception_stage_if.sv | 48 ++++
 rtl/wb_exception_stage_exc_cause_encode.sv | 46 ++++
 rtl/wb_exception_stage.sv | 148 ++++++++++++++
 tb/tb_wb_exception_stage.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_exception_stage_pkg.sv
// Shared constants for the writeback exception stage: cause codes,
// default special-register indices and exception-mask bit positions.
package wb_exception_stage_pkg;

    localparam logic [2:0] EXC_NONE  = 3'd0;
    localparam logic [2:0] EXC_ADD_R = 3'd1;
    localparam logic [2:0] EXC_ADD_I = 3'd2;
    localparam logic [2:0] EXC_SUB_R = 3'd3;
    localparam logic [2:0] EXC_MUL   = 3'd4;
    localparam logic [2:0] EXC_DIV   = 3'd5;

    localparam int DEF_STATUS_REG = 30;
    localparam int DEF_LINK_REG   = 31;

    localparam int MASK_ADD_R = 0;
    localparam int MASK_ADD_I = 1;
    localparam int MASK_SUB_R = 2;
    localparam int MASK_MUL   = 3;
    localparam int MASK_DIV   = 4;

endpackage

// File: rtl/wb_exception_stage_if.sv
// Writeback-stage bundle: upstream instruction fields in, register-file
// write and sticky exception status out.
interface wb_exception_stage_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 12,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 8
);
    logic              stall;
    logic              in_valid;
    logic              in_we;
    logic [DATA_W-1:0] in_data;
    logic [REG_W-1:0]  in_reg;
    logic [PC_W-1:0]   pc;
    logic              is_add_r;
    logic              is_add_i;
    logic              is_sub_r;
    logic              is_mul;
    logic              is_div;
    logic              exc_flag;
    logic              is_jal;
    logic [4:0]        exc_mask;
    logic              clear_exc;
    logic              out_valid;
    logic              out_we;
    logic [DATA_W-1:0] out_data;
    logic [REG_W-1:0]  out_reg;
    logic              exc_pending;
    logic [2:0]        exc_code;
    logic [CNT_W-1:0]  exc_count;

    modport master (
        output stall, in_valid, in_we, in_data, in_reg, pc,
               is_add_r, is_add_i, is_sub_r, is_mul, is_div,
               exc_flag, is_jal, exc_mask, clear_exc,
        input  out_valid, out_we, out_data, out_reg,
               exc_pending, exc_code, exc_count
    );

    modport slave (
        input  stall, in_valid, in_we, in_data, in_reg, pc,
               is_add_r, is_add_i, is_sub_r, is_mul, is_div,
               exc_flag, is_jal, exc_mask, clear_exc,
        output out_valid, out_we, out_data, out_reg,
               exc_pending, exc_code, exc_count
    );

endinterface

// File: rtl/wb_exception_stage_exc_cause_encode.sv
// Combinational cause encoder: picks the lowest-coded active op class and
// raises exc only if that class's mask bit is enabled.
module exc_cause_encode
    import wb_exception_stage_pkg::*;
(
    input  logic       valid,
    input  logic       exc_flag,
    input  logic       is_add_r,
    input  logic       is_add_i,
    input  logic       is_sub_r,
    input  logic       is_mul,
    input  logic       is_div,
    input  logic [4:0] mask,
    output logic       exc,
    output logic [2:0] code
);

    logic enable_s;

    // priority select of op class and its mask enable
    always_comb begin
        code     = EXC_NONE;
        enable_s = 1'b0;
        if (is_add_r) begin
            code     = EXC_ADD_R;
            enable_s = mask[MASK_ADD_R];
        end else if (is_add_i) begin
            code     = EXC_ADD_I;
            enable_s = mask[MASK_ADD_I];
        end else if (is_sub_r) begin
            code     = EXC_SUB_R;
            enable_s = mask[MASK_SUB_R];
        end else if (is_mul) begin
            code     = EXC_MUL;
            enable_s = mask[MASK_MUL];
        end else if (is_div) begin
            code     = EXC_DIV;
            enable_s = mask[MASK_DIV];
        end else begin
            code     = EXC_NONE;
            enable_s = 1'b0;
        end
        exc = valid & exc_flag & enable_s;
    end

endmodule

// File: rtl/wb_exception_stage.sv
// Registered writeback-select stage: chooses link, status or normal write
// and keeps a sticky first-exception record plus a saturating counter.
module wb_exception_stage
    import wb_exception_stage_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 12,
    parameter int REG_W      = 5,
    parameter int STATUS_REG = DEF_STATUS_REG,
    parameter int LINK_REG   = DEF_LINK_REG,
    parameter int CNT_W      = 8
) (
    input logic                 clock,
    input logic                 reset,
    wb_exception_stage_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              exc_s;
    logic [2:0]        code_s;
    logic              take_exc_s;
    logic [PC_W-1:0]   pc_inc_s;
    logic              nxt_we_s;
    logic [DATA_W-1:0] nxt_data_s;
    logic [REG_W-1:0]  nxt_reg_s;
    logic              nxt_pend_s;
    logic [2:0]        nxt_code_s;
    logic [CNT_W-1:0]  nxt_count_s;

    logic              out_valid_r;
    logic              out_we_r;
    logic [DATA_W-1:0] out_data_r;
    logic [REG_W-1:0]  out_reg_r;
    logic              pend_r;
    logic [2:0]        code_r;
    logic [CNT_W-1:0]  count_r;

    exc_cause_encode u_encode (
        .valid    (bus.in_valid),
        .exc_flag (bus.exc_flag),
        .is_add_r (bus.is_add_r),
        .is_add_i (bus.is_add_i),
        .is_sub_r (bus.is_sub_r),
        .is_mul   (bus.is_mul),
        .is_div   (bus.is_div),
        .mask     (bus.exc_mask),
        .exc      (exc_s),
        .code     (code_s)
    );

    // jal overrides the exception entirely, including the sticky record
    assign take_exc_s = exc_s & ~bus.is_jal;
    assign pc_inc_s   = bus.pc + PC_W'(1);

    // writeback selection: link, status or pass-through
    always_comb begin
        nxt_we_s   = 1'b0;
        nxt_data_s = '0;
        nxt_reg_s  = '0;
        if (!bus.in_valid) begin
            nxt_we_s   = 1'b0;
            nxt_data_s = '0;
            nxt_reg_s  = '0;
        end else if (bus.is_jal) begin
            nxt_we_s   = 1'b1;
            nxt_data_s = DATA_W'(pc_inc_s);
            nxt_reg_s  = REG_W'(LINK_REG);
        end else if (exc_s) begin
            nxt_we_s   = 1'b1;
            nxt_data_s = DATA_W'(code_s);
            nxt_reg_s  = REG_W'(STATUS_REG);
        end else begin
            nxt_we_s   = bus.in_we;
            nxt_data_s = bus.in_data;
            nxt_reg_s  = bus.in_reg;
        end
    end

    // sticky record and counter; a same-cycle exception beats clear_exc
    always_comb begin
        nxt_pend_s  = pend_r;
        nxt_code_s  = code_r;
        nxt_count_s = count_r;
        if (take_exc_s) begin
            if (bus.clear_exc || !pend_r) begin
                nxt_pend_s = 1'b1;
                nxt_code_s = code_s;
            end else begin
                nxt_pend_s = pend_r;
                nxt_code_s = code_r;
            end
            if (bus.clear_exc) begin
                nxt_count_s = CNT_W'(1);
            end else if (count_r == CNT_MAX) begin
                nxt_count_s = count_r;
            end else begin
                nxt_count_s = count_r + CNT_W'(1);
            end
        end else if (bus.clear_exc) begin
            nxt_pend_s  = 1'b0;
            nxt_code_s  = EXC_NONE;
            nxt_count_s = '0;
        end else begin
            nxt_pend_s  = pend_r;
            nxt_code_s  = code_r;
            nxt_count_s = count_r;
        end
    end

    // state registers; stall freezes everything
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_we_r    <= 1'b0;
            out_data_r  <= '0;
            out_reg_r   <= '0;
            pend_r      <= 1'b0;
            code_r      <= EXC_NONE;
            count_r     <= '0;
        end else if (!bus.stall) begin
            out_valid_r <= bus.in_valid;
            out_we_r    <= nxt_we_s;
            out_data_r  <= nxt_data_s;
            out_reg_r   <= nxt_reg_s;
            pend_r      <= nxt_pend_s;
            code_r      <= nxt_code_s;
            count_r     <= nxt_count_s;
        end else begin
            out_valid_r <= out_valid_r;
            out_we_r    <= out_we_r;
            out_data_r  <= out_data_r;
            out_reg_r   <= out_reg_r;
            pend_r      <= pend_r;
            code_r      <= code_r;
            count_r     <= count_r;
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.out_we      = out_we_r;
    assign bus.out_data    = out_data_r;
    assign bus.out_reg     = out_reg_r;
    assign bus.exc_pending = pend_r;
    assign bus.exc_code    = code_r;
    assign bus.exc_count   = count_r;

endmodule

// File: tb/tb_wb_exception_stage.sv
// Bench for wb_exception_stage: directed scenarios plus random traffic against
// a behavioural model, on an 8-bit-counter and a 2-bit-counter instance.
module tb_wb_exception_stage;

    logic clock;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    wb_exception_stage_if #(.DATA_W(32), .PC_W(12), .REG_W(5), .CNT_W(8)) ifa ();
    wb_exception_stage_if #(.DATA_W(32), .PC_W(12), .REG_W(5), .CNT_W(2)) ifb ();

    wb_exception_stage #(.CNT_W(8)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
    wb_exception_stage #(.CNT_W(2)) dut_b (.clock(clock), .reset(reset), .bus(ifb));

    assign ifb.stall     = ifa.stall;
    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.in_we     = ifa.in_we;
    assign ifb.in_data   = ifa.in_data;
    assign ifb.in_reg    = ifa.in_reg;
    assign ifb.pc        = ifa.pc;
    assign ifb.is_add_r  = ifa.is_add_r;
    assign ifb.is_add_i  = ifa.is_add_i;
    assign ifb.is_sub_r  = ifa.is_sub_r;
    assign ifb.is_mul    = ifa.is_mul;
    assign ifb.is_div    = ifa.is_div;
    assign ifb.exc_flag  = ifa.exc_flag;
    assign ifb.is_jal    = ifa.is_jal;
    assign ifb.exc_mask  = ifa.exc_mask;
    assign ifb.clear_exc = ifa.clear_exc;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // behavioural model state
    bit          m_valid, m_we, m_pend;
    logic [31:0] m_data;
    logic [4:0]  m_reg;
    int          m_code, m_cnt8, m_cnt2;

    logic [50:0] obs_a;
    logic [44:0] obs_b;
    assign obs_a = {ifa.out_valid, ifa.out_we, ifa.out_data, ifa.out_reg,
                    ifa.exc_pending, ifa.exc_code, ifa.exc_count};
    assign obs_b = {ifb.out_valid, ifb.out_we, ifb.out_data, ifb.out_reg,
                    ifb.exc_pending, ifb.exc_code, ifb.exc_count};

    function automatic logic [50:0] exp_a();
        return {m_valid, m_we, m_data, m_reg, m_pend, 3'(m_code), 8'(m_cnt8)};
    endfunction

    function automatic logic [44:0] exp_b();
        return {m_valid, m_we, m_data, m_reg, m_pend, 3'(m_code), 2'(m_cnt2)};
    endfunction

    task automatic model_clear_all();
        m_valid = 1'b0; m_we = 1'b0; m_data = 32'd0; m_reg = 5'd0;
        m_pend = 1'b0; m_code = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    task automatic idle_inputs();
        ifa.stall = 1'b0; ifa.in_valid = 1'b0; ifa.in_we = 1'b0;
        ifa.in_data = 32'd0; ifa.in_reg = 5'd0; ifa.pc = 12'd0;
        ifa.is_add_r = 1'b0; ifa.is_add_i = 1'b0; ifa.is_sub_r = 1'b0;
        ifa.is_mul = 1'b0; ifa.is_div = 1'b0; ifa.exc_flag = 1'b0;
        ifa.is_jal = 1'b0; ifa.exc_mask = 5'h1F; ifa.clear_exc = 1'b0;
    endtask

    // op: 1=add_r 2=add_i 3=sub_r 4=mul 5=div, 0=none
    task automatic set_op(input int op);
        ifa.is_add_r = (op == 1); ifa.is_add_i = (op == 2); ifa.is_sub_r = (op == 3);
        ifa.is_mul   = (op == 4); ifa.is_div   = (op == 5);
    endtask

    // update the model from the spec rules, then clock the DUTs
    task automatic advance();
        logic [4:0] ops;
        int         sel;
        bit         exc;
        ops = {ifa.is_div, ifa.is_mul, ifa.is_sub_r, ifa.is_add_i, ifa.is_add_r};
        sel = 0;
        for (int i = 4; i >= 0; i--) if (ops[i]) sel = i + 1;
        exc = ifa.in_valid && ifa.exc_flag && sel != 0 && ifa.exc_mask[sel-1];
        if (!ifa.stall) begin
            m_valid = ifa.in_valid;
            if (!ifa.in_valid) begin
                m_we = 1'b0; m_data = 32'd0; m_reg = 5'd0;
            end else if (ifa.is_jal) begin
                m_we = 1'b1; m_reg = 5'd31;
                m_data = 32'((int'(ifa.pc) + 1) % 4096);
            end else if (exc) begin
                m_we = 1'b1; m_reg = 5'd30; m_data = 32'(sel);
            end else begin
                m_we = ifa.in_we; m_reg = ifa.in_reg; m_data = ifa.in_data;
            end
            if (exc && !ifa.is_jal) begin
                if (ifa.clear_exc || !m_pend) begin
                    m_pend = 1'b1; m_code = sel;
                end
                m_cnt8 = ifa.clear_exc ? 1 : ((m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1);
                m_cnt2 = ifa.clear_exc ? 1 : ((m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1);
            end else if (ifa.clear_exc) begin
                m_pend = 1'b0; m_code = 0; m_cnt8 = 0; m_cnt2 = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (obs_a !== 51'd0) begin
            $display("FAIL reset_a got=%h exp=0", obs_a); n_bad++;
        end
        n_cmp++;
        if (obs_b !== 45'd0) begin
            $display("FAIL reset_b got=%h exp=0", obs_b); n_bad++;
        end
        reset = 1'b1;
        model_clear_all();
    endtask

    task automatic test_exception();
        idle_inputs();
        ifa.in_valid = 1'b1; ifa.in_we = 1'b1; set_op(1); ifa.exc_flag = 1'b1;
        ifa.in_reg = 5'd7; ifa.in_data = 32'h55;
        advance();
        n_cmp++;
        if ({ifa.out_reg, ifa.out_data, ifa.out_we, ifa.exc_pending, ifa.exc_code, ifa.exc_count}
            !== {5'd30, 32'd1, 1'b1, 1'b1, 3'd1, 8'd1}) begin
            $display("FAIL add_r_exc got reg=%0d data=%h we=%b pend=%b code=%0d cnt=%0d exp 30/1/1/1/1/1",
                     ifa.out_reg, ifa.out_data, ifa.out_we, ifa.exc_pending, ifa.exc_code, ifa.exc_count);
            n_bad++;
        end
    endtask

    task automatic test_jal();
        idle_inputs();
        ifa.in_valid = 1'b1; ifa.is_jal = 1'b1; ifa.pc = 12'hFFF;
        set_op(1); ifa.exc_flag = 1'b1; ifa.in_reg = 5'd3;
        advance();
        n_cmp++;
        if ({ifa.out_reg, ifa.out_data, ifa.out_we, ifa.exc_pending, ifa.exc_code, ifa.exc_count}
            !== {5'd31, 32'd0, 1'b1, 1'b1, 3'd1, 8'd1}) begin
            $display("FAIL jal_wrap got reg=%0d data=%h cnt=%0d exp reg=31 data=0 cnt=1",
                     ifa.out_reg, ifa.out_data, ifa.exc_count);
            n_bad++;
        end
    endtask

    task automatic test_masked();
        idle_inputs();
        ifa.in_valid = 1'b1; ifa.in_we = 1'b1; set_op(4); ifa.exc_flag = 1'b1;
        ifa.exc_mask = 5'h17; ifa.in_reg = 5'd4; ifa.in_data = 32'h1234;
        ifa.clear_exc = 1'b1;
        advance();
        ifa.clear_exc = 1'b0;
        advance();
        n_cmp++;
        if ({ifa.out_reg, ifa.out_data, ifa.exc_pending, ifa.exc_count}
            !== {5'd4, 32'h1234, 1'b0, 8'd0}) begin
            $display("FAIL masked_mul got reg=%0d data=%h pend=%b cnt=%0d exp 4/1234/0/0",
                     ifa.out_reg, ifa.out_data, ifa.exc_pending, ifa.exc_count);
            n_bad++;
        end
    endtask

    task automatic test_sticky();
        idle_inputs();
        ifa.in_valid = 1'b1; ifa.exc_flag = 1'b1;
        set_op(3); advance();
        set_op(5); advance();
        n_cmp++;
        if ({ifa.exc_pending, ifa.exc_code, ifa.exc_count, ifa.out_data}
            !== {1'b1, 3'd3, 8'd2, 32'd5}) begin
            $display("FAIL sticky_first got pend=%b code=%0d cnt=%0d data=%h exp 1/3/2/5",
                     ifa.exc_pending, ifa.exc_code, ifa.exc_count, ifa.out_data);
            n_bad++;
        end
        set_op(2); ifa.clear_exc = 1'b1; advance();
        n_cmp++;
        if ({ifa.exc_pending, ifa.exc_code, ifa.exc_count} !== {1'b1, 3'd2, 8'd1}) begin
            $display("FAIL clear_vs_exc got pend=%b code=%0d cnt=%0d exp 1/2/1",
                     ifa.exc_pending, ifa.exc_code, ifa.exc_count);
            n_bad++;
        end
    endtask

    task automatic test_saturate();
        logic [1:0] want [5];
        want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        idle_inputs();
        ifa.clear_exc = 1'b1; advance();
        ifa.clear_exc = 1'b0; ifa.in_valid = 1'b1; ifa.exc_flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_op(1 + (i % 5));
            advance();
            n_cmp++;
            if (ifb.exc_count !== want[i] || obs_a !== exp_a()) begin
                $display("FAIL saturate[%0d] got cnt2=%0d cnt8=%0d exp cnt2=%0d cnt8=%0d",
                         i, ifb.exc_count, ifa.exc_count, want[i], m_cnt8);
                n_bad++;
            end
        end
    endtask

    task automatic test_stall();
        idle_inputs();
        ifa.stall = 1'b1; ifa.in_valid = 1'b1; set_op(3); ifa.exc_flag = 1'b1;
        ifa.clear_exc = 1'b1;
        advance();
        advance();
        n_cmp++;
        if (obs_b !== exp_b() || ifb.exc_count !== 2'd3 || ifa.exc_code !== 3'd1
            || ifa.out_data !== 32'd5) begin
            $display("FAIL stall_hold got %h exp %h", obs_b, exp_b());
            n_bad++;
        end
        ifa.stall = 1'b0;
    endtask

    task automatic test_async_reset();
        idle_inputs();
        ifa.in_valid = 1'b1; ifa.in_we = 1'b1; ifa.in_reg = 5'd12; ifa.in_data = 32'hBEEF;
        advance();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs_a !== 51'd0 || obs_b !== 45'd0) begin
            $display("FAIL async_reset got a=%h b=%h exp 0", obs_a, obs_b);
            n_bad++;
        end
        model_clear_all();
        reset = 1'b1;
        idle_inputs();
        ifa.in_valid = 1'b1; ifa.in_we = 1'b1; set_op(2);
        ifa.in_reg = 5'd9; ifa.in_data = 32'hA;
        advance();
        n_cmp++;
        if ({ifa.out_valid, ifa.out_we, ifa.out_reg, ifa.out_data, ifa.exc_pending}
            !== {1'b1, 1'b1, 5'd9, 32'hA, 1'b0}) begin
            $display("FAIL post_reset_addi got reg=%0d data=%h exp reg=9 data=a",
                     ifa.out_reg, ifa.out_data);
            n_bad++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            ifa.stall     = ($urandom_range(0, 7) == 0);
            ifa.in_valid  = ($urandom_range(0, 5) != 0);
            ifa.in_we     = 1'($urandom);
            ifa.in_data   = $urandom;
            ifa.in_reg    = 5'($urandom);
            ifa.pc        = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom);
            if ($urandom_range(0, 1) == 0) set_op($urandom_range(0, 5));
            else {ifa.is_div, ifa.is_mul, ifa.is_sub_r, ifa.is_add_i, ifa.is_add_r} = 5'($urandom);
            ifa.exc_flag  = ($urandom_range(0, 2) != 0);
            ifa.is_jal    = ($urandom_range(0, 5) == 0);
            ifa.exc_mask  = ($urandom_range(0, 1) == 0) ? 5'h1F : 5'($urandom);
            ifa.clear_exc = ($urandom_range(0, 9) == 0);
            advance();
            n_cmp++;
            if (obs_a !== exp_a()) begin
                $display("FAIL random_a[%0d] got=%h exp=%h", i, obs_a, exp_a()); n_bad++;
            end
            n_cmp++;
            if (obs_b !== exp_b()) begin
                $display("FAIL random_b[%0d] got=%h exp=%h", i, obs_b, exp_b()); n_bad++;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_clear_all();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_exception();
        test_jal();
        test_masked();
        test_sticky();
        test_saturate();
        test_stall();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
